// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one ALU between two requesters with registered response slots
// Optional: define ALU_SHARE_ARB_PERF_EN to add perf_grant_0/perf_grant_1/perf_conflict counters.
module alu_share_arb #(
    parameter int WIDTH   = 64,
    parameter int CNTRL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid_0,
    input  logic               req_valid_1,
    output logic               req_ready_0,
    output logic               req_ready_1,
    input  logic [WIDTH-1:0]   req_A_0,
    input  logic [WIDTH-1:0]   req_A_1,
    input  logic [WIDTH-1:0]   req_B_0,
    input  logic [WIDTH-1:0]   req_B_1,
    input  logic [CNTRL_W-1:0] req_cntrl_0,
    input  logic [CNTRL_W-1:0] req_cntrl_1,
    output logic               rsp_valid_0,
    output logic               rsp_valid_1,
    input  logic               rsp_ready_0,
    input  logic               rsp_ready_1,
    output logic [WIDTH-1:0]   rsp_result_0,
    output logic [WIDTH-1:0]   rsp_result_1,
    output logic [3:0]         rsp_flags_0,
    output logic [3:0]         rsp_flags_1,
    output logic               rsp_err_0,
    output logic               rsp_err_1,
    output logic [WIDTH-1:0]   alu_A,
    output logic [WIDTH-1:0]   alu_B,
    output logic [CNTRL_W-1:0] alu_cntrl,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_negative,
    input  logic               alu_zero,
    input  logic               alu_overflow,
`ifdef ALU_SHARE_ARB_PERF_EN
    output logic [31:0]        perf_grant_0,
    output logic [31:0]        perf_grant_1,
    output logic [31:0]        perf_conflict,
`endif
    input  logic               alu_carry_out
);

    localparam logic [CNTRL_W-1:0] OP_ILL_LO = CNTRL_W'(3'b001);
    localparam logic [CNTRL_W-1:0] OP_ILL_HI = CNTRL_W'(3'b111);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t slot_q_0, slot_q_1;
    slot_state_t slot_d_0, slot_d_1;

    logic               last_grant;
    logic               free_0, free_1;
    logic               elig_0, elig_1;
    logic               grant_0, grant_1;
    logic [WIDTH-1:0]   sel_A, sel_B;
    logic [CNTRL_W-1:0] sel_cntrl;
    logic               sel_illegal;
    logic [WIDTH-1:0]   load_result;
    logic [3:0]         load_flags;

    // A slot is free if empty or being drained this cycle, so a port can reissue back-to-back.
    always_comb begin
        free_0  = (slot_q_0 == SLOT_EMPTY) || rsp_ready_0;
        free_1  = (slot_q_1 == SLOT_EMPTY) || rsp_ready_1;
        elig_0  = req_valid_0 && free_0;
        elig_1  = req_valid_1 && free_1;
        grant_0 = !reset && elig_0 && (!elig_1 || last_grant);
        grant_1 = !reset && elig_1 && (!elig_0 || !last_grant);
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;

    // Illegal ops still transfer but keep the ALU quiet and load a zeroed error response.
    always_comb begin
        sel_A       = grant_1 ? req_A_1 : req_A_0;
        sel_B       = grant_1 ? req_B_1 : req_B_0;
        sel_cntrl   = grant_1 ? req_cntrl_1 : req_cntrl_0;
        sel_illegal = (sel_cntrl == OP_ILL_LO) || (sel_cntrl == OP_ILL_HI);
        alu_A       = '0;
        alu_B       = '0;
        alu_cntrl   = '0;
        if ((grant_0 || grant_1) && !sel_illegal) begin
            alu_A     = sel_A;
            alu_B     = sel_B;
            alu_cntrl = sel_cntrl;
        end
        load_result = sel_illegal ? '0 : alu_result;
        load_flags  = sel_illegal ? 4'b0000
                                  : {alu_negative, alu_zero, alu_overflow, alu_carry_out};
    end

    always_comb begin
        slot_d_0 = slot_q_0;
        slot_d_1 = slot_q_1;
        if (grant_0) begin
            slot_d_0 = SLOT_FULL;
        end else if (rsp_ready_0) begin
            slot_d_0 = SLOT_EMPTY;
        end
        if (grant_1) begin
            slot_d_1 = SLOT_FULL;
        end else if (rsp_ready_1) begin
            slot_d_1 = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q_0     <= SLOT_EMPTY;
            slot_q_1     <= SLOT_EMPTY;
            last_grant   <= 1'b1;
            rsp_result_0 <= '0;
            rsp_result_1 <= '0;
            rsp_flags_0  <= 4'b0000;
            rsp_flags_1  <= 4'b0000;
            rsp_err_0    <= 1'b0;
            rsp_err_1    <= 1'b0;
        end else begin
            slot_q_0 <= slot_d_0;
            slot_q_1 <= slot_d_1;
            if (grant_0) begin
                rsp_result_0 <= load_result;
                rsp_flags_0  <= load_flags;
                rsp_err_0    <= sel_illegal;
                last_grant   <= 1'b0;
            end
            if (grant_1) begin
                rsp_result_1 <= load_result;
                rsp_flags_1  <= load_flags;
                rsp_err_1    <= sel_illegal;
                last_grant   <= 1'b1;
            end
        end
    end

    assign rsp_valid_0 = (slot_q_0 == SLOT_FULL);
    assign rsp_valid_1 = (slot_q_1 == SLOT_FULL);

`ifdef ALU_SHARE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant_0  <= '0;
            perf_grant_1  <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant_0) begin
                perf_grant_0 <= perf_grant_0 + 32'd1;
            end
            if (grant_1) begin
                perf_grant_1 <= perf_grant_1 + 32'd1;
            end
            if (elig_0 && elig_1) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb with an emulated ALU
module tb_alu_share_arb;
    localparam int W  = 64;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [W-1:0]  req_A_0, req_A_1, req_B_0, req_B_1;
    logic [CW-1:0] req_cntrl_0, req_cntrl_1;
    logic          rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [W-1:0]  rsp_result_0, rsp_result_1;
    logic [3:0]    rsp_flags_0, rsp_flags_1;
    logic          rsp_err_0, rsp_err_1;
    logic [W-1:0]  alu_A, alu_B, alu_result;
    logic [CW-1:0] alu_cntrl;
    logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0]   perf_grant_0, perf_grant_1, perf_conflict;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(W), .CNTRL_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_A_0(req_A_0), .req_A_1(req_A_1), .req_B_0(req_B_0), .req_B_1(req_B_1),
        .req_cntrl_0(req_cntrl_0), .req_cntrl_1(req_cntrl_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
        .rsp_flags_0(rsp_flags_0), .rsp_flags_1(rsp_flags_1),
        .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
`ifdef ALU_SHARE_ARB_PERF_EN
        .perf_grant_0(perf_grant_0), .perf_grant_1(perf_grant_1), .perf_conflict(perf_conflict),
`endif
        .alu_carry_out(alu_carry_out)
    );

    // Emulated ALU: returns {negative, zero, overflow, carry_out, result}.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [CW-1:0] c);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v, co;
        s = '0; r = '0; v = 1'b0; co = 1'b0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; co = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[W-1:0]; co = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        return {r[W-1], (r == '0), v, co, r};
    endfunction

    always_comb {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} = alu_fn(alu_A, alu_B, alu_cntrl);

    // Expected response record {err, flags, result} for an op as submitted by a requester.
    function automatic logic [W+4:0] exp_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [CW-1:0] c);
        if (c == 3'b001 || c == 3'b111) return {1'b1, 4'b0000, {W{1'b0}}};
        return {1'b0, alu_fn(a, b, c)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 1; rsp_ready_1 = 1;
        req_A_0 = '0; req_B_0 = '0; req_cntrl_0 = '0;
        req_A_1 = '0; req_B_1 = '0; req_cntrl_1 = '0;
    endtask

    task automatic set_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [CW-1:0] c);
        if (p == 0) begin req_valid_0 = 1; req_A_0 = a; req_B_0 = b; req_cntrl_0 = c; end
        else        begin req_valid_1 = 1; req_A_1 = a; req_B_1 = b; req_cntrl_1 = c; end
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    typedef struct {
        int            p;
        logic [W-1:0]  a, b;
        logic [CW-1:0] c;
        logic [W-1:0]  r;
        logic [3:0]    f;
        logic          e;
    } vec_t;

    vec_t tbl[11];

    logic          m_full[2];
    logic [W+4:0]  m_data[2];
    int            m_lg;

    initial begin
        tbl[0]  = '{0, 64'd5, 64'd7, 3'b010, 64'd12, 4'b0000, 1'b0};
        tbl[1]  = '{0, 64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0};
        tbl[2]  = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 4'b1010, 1'b0};
        tbl[3]  = '{0, 64'd9, 64'd9, 3'b011, 64'd0, 4'b0101, 1'b0};
        tbl[4]  = '{1, 64'hF0F0, 64'h0FF0, 3'b100, 64'h00F0, 4'b0000, 1'b0};
        tbl[5]  = '{1, 64'hF000_0000_0000_0000, 64'd1, 3'b101, 64'hF000_0000_0000_0001, 4'b1000, 1'b0};
        tbl[6]  = '{1, 64'd5, 64'd5, 3'b110, 64'd0, 4'b0100, 1'b0};
        tbl[7]  = '{0, 64'h1234, 64'h1234, 3'b000, 64'h1234, 4'b0000, 1'b0};
        tbl[8]  = '{1, 64'd3, 64'd4, 3'b111, 64'd0, 4'b0000, 1'b1};
        tbl[9]  = '{0, 64'd6, 64'd2, 3'b001, 64'd0, 4'b0000, 1'b1};
        tbl[10] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 4'b0101, 1'b0};

        // Reset state, with both requesters active during reset.
        idle();
        reset = 1;
        set_op(0, 64'd1, 64'd2, 3'b010);
        set_op(1, 64'd3, 64'd4, 3'b010);
        tick();
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_alu", {alu_A, alu_B, alu_cntrl}, 0);
        chk("rst_rsp0", {rsp_valid_0, rsp_err_0, rsp_flags_0, rsp_result_0}, 0);
        chk("rst_rsp1", {rsp_valid_1, rsp_err_1, rsp_flags_1, rsp_result_1}, 0);
        idle();
        reset = 0;
        tick();

        // Table-driven single-port ops; each consumes the previous response in the same cycle.
        for (int i = 0; i < 11; i++) begin
            idle();
            set_op(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].c);
            #2;
            chk($sformatf("tbl%0d_ready", i), (tbl[i].p == 0) ? req_ready_0 : req_ready_1, 1);
            chk($sformatf("tbl%0d_alu", i), {alu_A, alu_cntrl},
                tbl[i].e ? 0 : {tbl[i].a, tbl[i].c});
            tick();
            if (tbl[i].p == 0)
                chk($sformatf("tbl%0d_rsp", i), {rsp_valid_0, rsp_err_0, rsp_flags_0, rsp_result_0},
                    {1'b1, tbl[i].e, tbl[i].f, tbl[i].r});
            else
                chk($sformatf("tbl%0d_rsp", i), {rsp_valid_1, rsp_err_1, rsp_flags_1, rsp_result_1},
                    {1'b1, tbl[i].e, tbl[i].f, tbl[i].r});
        end

        // Alternating grants on a continuous tie, port 0 first after reset.
        do_reset();
        set_op(0, 64'd3, 64'd5, 3'b011);
        set_op(1, 64'hAA, 64'h55, 3'b110);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("alt%0d_grant", k), {req_ready_0, req_ready_1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            if (k == 0) chk("alt_sub_rsp", {rsp_flags_0[3], rsp_result_0}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
            if (k == 1) chk("alt_xor_rsp", rsp_result_1, 64'hFF);
        end

        // Port 0 stalls its response: port 1 takes every cycle and slot 0 holds.
        rsp_ready_0 = 0;
        set_op(0, 64'd5, 64'd7, 3'b010);
        #2;
        chk("stall_first_grant0", req_ready_0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("stall%0d_grant", k), {req_ready_0, req_ready_1}, 2'b01);
            tick();
            chk($sformatf("stall%0d_hold", k), {rsp_valid_0, rsp_flags_0, rsp_result_0}, {1'b1, 4'b0000, 64'd12});
        end
        rsp_ready_0 = 1;
        rsp_ready_1 = 0;
        set_op(0, 64'd9, 64'd9, 3'b011);
        #2;
        chk("unstall_grant", {req_ready_0, req_ready_1}, 2'b10);
        tick();
        chk("unstall_rsp", {rsp_valid_0, rsp_flags_0, rsp_result_0}, {1'b1, 4'b0101, 64'd0});

        // Reset with a full slot 1 and a transfer pending drops everything.
        chk("pre_rst_valid1", rsp_valid_1, 1);
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        reset = 1;
        tick();
        chk("midrst_valid", {rsp_valid_0, rsp_valid_1}, 2'b00);
        chk("midrst_result1", rsp_result_1, 0);
        reset = 0;
        #2;
        chk("postrst_tie", {req_ready_0, req_ready_1}, 2'b10);
        tick();
        #2;
        chk("postrst_tie2", {req_ready_0, req_ready_1}, 2'b01);
        tick();

        // Randomized traffic against a spec-level reference model.
        do_reset();
        m_full[0] = 0; m_full[1] = 0; m_lg = 1;
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0]  a[2], b[2];
            logic [CW-1:0] c[2];
            logic          v[2], rr[2], el[2];
            int            g;
            for (int p = 0; p < 2; p++) begin
                v[p]  = ($urandom_range(0, 3) != 0);
                rr[p] = ($urandom_range(0, 2) != 0);
                c[p]  = CW'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: a[p] = 64'h7FFF_FFFF_FFFF_FFFF;
                    1: a[p] = W'($urandom_range(0, 15));
                    default: a[p] = {$urandom, $urandom};
                endcase
                b[p] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : {$urandom, $urandom};
            end
            req_valid_0 = v[0]; req_A_0 = a[0]; req_B_0 = b[0]; req_cntrl_0 = c[0]; rsp_ready_0 = rr[0];
            req_valid_1 = v[1]; req_A_1 = a[1]; req_B_1 = b[1]; req_cntrl_1 = c[1]; rsp_ready_1 = rr[1];
            #2;
            for (int p = 0; p < 2; p++) el[p] = v[p] && (!m_full[p] || rr[p]);
            if (el[0] && el[1]) g = (m_lg == 1) ? 0 : 1;
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
            else                g = -1;
            chk($sformatf("rnd%0d_grant", n), {req_ready_0, req_ready_1}, {g == 0, g == 1});
            for (int p = 0; p < 2; p++) begin
                if (p == g) begin
                    m_full[p] = 1;
                    m_data[p] = exp_rsp(a[p], b[p], c[p]);
                end else if (rr[p]) begin
                    m_full[p] = 0;
                end
            end
            if (g >= 0) m_lg = g;
            tick();
            chk($sformatf("rnd%0d_valid", n), {rsp_valid_0, rsp_valid_1}, {m_full[0], m_full[1]});
            if (m_full[0]) chk($sformatf("rnd%0d_rsp0", n), {rsp_err_0, rsp_flags_0, rsp_result_0}, m_data[0]);
            if (m_full[1]) chk($sformatf("rnd%0d_rsp1", n), {rsp_err_1, rsp_flags_1, rsp_result_1}, m_data[1]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 64-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-compare unit.
- Arbitrates requests round-robin and drives the ALU operand/control inputs combinationally.
- Registers the ALU result and flags into a one-entry response slot per requester.
- Sits between the pipeline front-ends and the ALU instance; owns all ALU sequencing.

Parameters:
- WIDTH, 64: operand/result width; must match the ALU width.
- CNTRL_W, 3: ALU control code width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_0, req_valid_1  input  1 each  requester has an operation.
- req_ready_0, req_ready_1  output  1 each  operation accepted this cycle.
- req_A_0, req_A_1  input  WIDTH each  operand A.
- req_B_0, req_B_1  input  WIDTH each  operand B.
- req_cntrl_0, req_cntrl_1  input  CNTRL_W each  ALU op: 000 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
- rsp_valid_0, rsp_valid_1  output  1 each  response slot full.
- rsp_ready_0, rsp_ready_1  input  1 each  requester consumes response.
- rsp_result_0, rsp_result_1  output  WIDTH each  registered ALU result.
- rsp_flags_0, rsp_flags_1  output  4 each  {negative, zero, overflow, carry_out}.
- rsp_err_0, rsp_err_1  output  1 each  illegal cntrl code (001 or 111).
- alu_A, alu_B  output  WIDTH each  to ALU.
- alu_cntrl  output  CNTRL_W  to ALU.
- alu_result  input  WIDTH  from ALU.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  from ALU.

Behaviour:
- Slot i is "free" when empty, or full with rsp_ready_i=1 this cycle.
- Eligibility: requester i is eligible when req_valid_i=1 and slot i is free.
- Grant rule:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not in last_grant.
  - last_grant updates only on a transfer.
  - Reset value last_grant=1, so port 0 wins the first tie.
- req_ready_i=1 only for the granted requester. It is combinational from the valids, slot states and rsp_ready.
- Transfer happens when req_valid_i && req_ready_i. At most one transfer per cycle.
- ALU drive:
  - alu_A/alu_B/alu_cntrl carry the granted requester's operands.
  - With no grant they are driven to 0/0/000, so the ALU is quiet (MOV of 0).
- Latency: transfer in cycle N gives rsp_valid_i=1 from cycle N+1. The slot captures alu_result and flags at the end of cycle N.
- Slot i states:
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on rsp_ready_i without a new transfer.
  - FULL -> FULL (new data) on rsp_ready_i with a same-cycle transfer.
  - While FULL and not consumed, result, flags and err hold stable.
- Throughput: one op/cycle in total. The same port may issue back-to-back if it consumes its response in the same cycle.
- Illegal cntrl (001/111):
  - Op is accepted and the ALU is not driven (inputs forced 0/0/000).
  - Slot loads result=0, flags=0000, err=1.
  - Legal ops load err=0.
- rsp_ready_i while the slot is EMPTY is ignored.
- Reset:
  - All rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, req_ready=0, last_grant=1, alu_* = 0.
  - Reset mid-operation drops any in-flight or unconsumed responses; nothing is replayed.
- Starvation bound: with both ports continuously eligible, each is granted at least every 2 cycles.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- When defined, add outputs perf_grant_0, perf_grant_1 and perf_conflict (each 32 bits):
  - perf_grant_i counts transfers per port.
  - perf_conflict counts cycles where both ports were eligible.
  - All counters wrap at 2^32-1 -> 0 and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port 0 only, ADD A=5 B=7, rsp_ready_0=1 -> req_ready_0 same cycle; next cycle rsp_valid_0=1, result=12, flags=0000.
- Both ports valid every cycle after reset, SUB 3-5 on port 0 and XOR on port 1 -> grants alternate 0,1,0,1. Port 0 result=0xFFFF_FFFF_FFFF_FFFE, negative=1.
- Port 0 holds rsp_ready_0=0 after one op, then keeps requesting -> req_ready_0 stays 0, port 1 granted every cycle, slot 0 data stable. Raise rsp_ready_0 -> port 0 regranted.
- Port 1 cntrl=111 -> rsp_err_1=1, result=0, alu_cntrl observed 000.
- ADD A=0x7FFF_FFFF_FFFF_FFFF B=1 -> overflow=1, negative=1, carry_out=0. SUB A=B=9 -> zero=1, carry_out=1.
- Assert reset while rsp_valid_1=1 and a new transfer is occurring -> next cycle all rsp_valid=0, and a port-0/port-1 tie grants port 0 first.
